// File: rtl/larng_pkg.sv
// Shared constants and types for the larng_stream random-word generator.
package larng_pkg;

  // Register offsets within the Wishbone window
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_DATA   = 32'h0000_0008;
  localparam logic [31:0] OFF_SEED   = 32'h0000_000C;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_SPI_EN = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLUSH  = 3;
  localparam int CTRL_THRESH = 8;

  // STATUS bit positions
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UNF   = 19;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  // Stored CTRL fields; FLUSH is a pulse and is not held
  typedef struct packed {
    logic [7:0] thresh;
    logic       irq_en;
    logic       spi_en;
    logic       en;
  } ctrl_t;

  // One Galois step; the entropy bit is folded into the new bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic e);
    lfsr_step = ({1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0)) ^ {31'd0, e};
  endfunction

endpackage

// File: rtl/larng_fifo.sv
// Synchronous word FIFO with simultaneous push/pop and a flush that overrides both.
module larng_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // A push into a full FIFO is still accepted when a pop frees the slot
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rptr];

  // Storage write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/larng_stream.sv
// Wishbone-mapped random-word generator: whitened LFSR, word FIFO, serial
// shift-out on an external clock, and a threshold/overflow interrupt.
module larng_stream
  import larng_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3013_3700,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] LFSR_SEED   = DEFAULT_SEED,
  parameter int          SYNC_STAGES = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  input  logic          i_entropy,
  input  logic          i_spi_clk,
  output logic          o_spi_data,
  output logic          o_irq,
  output logic [127:0]  o_debug
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  ctrl_t                  ctrl;
  logic [31:0]            lfsr, sh, off, ctrl_rd, status_rd, rd_mux, fifo_rdata;
  logic [4:0]             step_cnt;
  logic [5:0]             bcnt;
  logic [SYNC_STAGES-1:0] ent_sync, spi_sync;
  logic                   spi_prev, spi_rise, ent_s;
  logic                   req, wr_ctrl, wr_status, wr_seed, rd_data, flush;
  logic                   push, spi_load, fifo_pop, fifo_full, fifo_empty;
  logic                   ovf, unf;
  logic [LW-1:0]          fifo_level;
  logic [8:0]             lvl9;
  logic                   unused_sel;

  assign unused_sel = ^wbs_sel_i;

  // Bus decode; an ack cycle blocks re-acceptance so each access takes two cycles
  assign off       = wbs_adr_i & ~ADDR_MASK;
  assign req       = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & ~wbs_ack_o;
  assign wr_ctrl   = req &  wbs_we_i & (off == OFF_CTRL);
  assign wr_status = req &  wbs_we_i & (off == OFF_STATUS);
  assign wr_seed   = req &  wbs_we_i & (off == OFF_SEED);
  assign rd_data   = req & ~wbs_we_i & (off == OFF_DATA);
  assign flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];

  assign ent_s    = ent_sync[SYNC_STAGES-1];
  assign spi_rise = spi_sync[SYNC_STAGES-1] & ~spi_prev;

  // A seed write takes precedence over stepping and resets the word counter
  assign push     = ctrl.en & ~wr_seed & (step_cnt == 5'd31);
  // A bus pop in the same cycle steals the serial load
  assign spi_load = spi_rise & ctrl.spi_en & (bcnt == 6'd0) & ~rd_data & ~fifo_empty;
  assign fifo_pop = rd_data | spi_load;

  larng_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (push),
    .wdata (lfsr_step(lfsr, ent_s)),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign lvl9      = 9'(fifo_level);
  assign ctrl_rd   = {16'd0, ctrl.thresh, 5'd0, ctrl.irq_en, ctrl.spi_en, ctrl.en};
  assign status_rd = {12'd0, unf, ovf, fifo_full, fifo_empty, 7'd0, lvl9};
  assign o_debug   = {sh, ctrl_rd, status_rd, lfsr};

  // Read data mux; unmapped offsets and an empty DATA read return 0
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CTRL:   rd_mux = ctrl_rd;
      OFF_STATUS: rd_mux = status_rd;
      OFF_DATA:   rd_mux = fifo_empty ? 32'h0 : fifo_rdata;
      default:    rd_mux = 32'h0;
    endcase
  end

  // Synchroniser chains for the asynchronous entropy and shift-clock pads
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ent_sync <= '0;
      spi_sync <= '0;
      spi_prev <= 1'b0;
    end else begin
      ent_sync <= {ent_sync[SYNC_STAGES-2:0], i_entropy};
      spi_sync <= {spi_sync[SYNC_STAGES-2:0], i_spi_clk};
      spi_prev <= spi_sync[SYNC_STAGES-1];
    end
  end

  // Wishbone response and control/status registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      ctrl      <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_mux : 32'h0;
      if (wr_ctrl)
        ctrl <= {wbs_dat_i[CTRL_THRESH +: 8], wbs_dat_i[CTRL_IRQ_EN],
                 wbs_dat_i[CTRL_SPI_EN], wbs_dat_i[CTRL_EN]};
      if (wr_status && wbs_dat_i[ST_OVF]) ovf <= 1'b0;
      if (wr_status && wbs_dat_i[ST_UNF]) unf <= 1'b0;
      if (push && fifo_full && !fifo_pop && !flush) ovf <= 1'b1;
      if (rd_data && fifo_empty) unf <= 1'b1;
      o_irq <= ctrl.irq_en & (((ctrl.thresh != 8'd0) & (lvl9 >= {1'b0, ctrl.thresh})) | ovf);
    end
  end

  // Generator: LFSR stepping and the 32-step word counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      lfsr     <= LFSR_SEED;
      step_cnt <= '0;
    end else if (wr_seed) begin
      lfsr     <= (wbs_dat_i == 32'h0) ? LFSR_SEED : wbs_dat_i;
      step_cnt <= '0;
    end else if (ctrl.en) begin
      lfsr     <= lfsr_step(lfsr, ent_s);
      step_cnt <= step_cnt + 5'd1;
    end
  end

  // Serial shift-out, MSB first, one bit per synchronised clock edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sh         <= 32'h0;
      bcnt       <= '0;
      o_spi_data <= 1'b0;
    end else if (flush) begin
      sh   <= 32'h0;
      bcnt <= '0;
    end else if (spi_rise && ctrl.spi_en) begin
      if (bcnt == 6'd0) begin
        if (spi_load) begin
          sh         <= fifo_rdata;
          o_spi_data <= fifo_rdata[31];
          bcnt       <= 6'd31;
        end else begin
          o_spi_data <= 1'b0;
        end
      end else begin
        sh         <= {sh[30:0], 1'b0};
        o_spi_data <= sh[30];
        bcnt       <= bcnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_larng_stream.sv
// Directed self-checking bench for larng_stream (depth 8, two-stage sync).
module tb_larng_stream;
  localparam logic [31:0] BASE = 32'h3013_3700;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8, A_SEED = BASE + 32'hC;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'hF;
  logic [31:0]  adr = '0, wdat = '0;
  logic [31:0]  dat_o;
  logic         ack, ent = 1'b0, spi_clk = 1'b0, spi_data, irq;
  logic [127:0] dbg;
  int           checks = 0, fails = 0;
  logic [31:0]  r, w;

  larng_stream dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .i_entropy(ent), .i_spi_clk(spi_clk),
    .o_spi_data(spi_data), .o_irq(irq), .o_debug(dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus access: request now, ack on the next edge, idle one cycle
  task automatic wb(input logic wr, input logic [31:0] a, input logic [31:0] d, output logic [31:0] q);
    stb = 1'b1; cyc = 1'b1; we = wr; adr = a; wdat = d;
    @(posedge clk); #1;
    chk("ack", ack, 1'b1);
    q = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb(1'b1, a, d, q);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wb(1'b0, a, 32'h0, q);
  endtask

  // Reference generator with entropy held at 0
  function automatic logic [31:0] model(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
      else      s = s >> 1;
    end
    return s;
  endfunction

  // Full pad clock: high phase then low phase, four cycles each
  task automatic spi_edge();
    spi_clk = 1'b1; tick(4);
    spi_clk = 1'b0; tick(4);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_debug", dbg, {32'h0, 32'h0, 32'h0001_0000, 32'hACE1_0001});
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_spi", spi_data, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Empty reads and underflow sticky bit
    rd(A_STAT, r); chk("stat_empty", r, 32'h0001_0000);
    rd(A_DATA, r); chk("data_empty", r, 32'h0);
    rd(A_STAT, r); chk("stat_unf", r, 32'h0009_0000);
    wr(A_STAT, 32'h0008_0000);
    rd(A_STAT, r); chk("stat_unf_clr", r, 32'h0001_0000);

    // First word after 32 steps from seed 1
    wr(A_SEED, 32'h1);
    wr(A_CTRL, 32'h1);
    tick(31);
    rd(A_DATA, r); chk("word32", r, model(32'h1, 32));
    wr(A_CTRL, 32'h0);
    rd(A_STAT, r); chk("level_back0", r, 32'h0001_0000);

    // Overflow: nine words into a depth-8 FIFO
    wr(A_SEED, 32'h1);
    wr(A_CTRL, 32'h5);
    tick(290);
    wr(A_CTRL, 32'h4);
    rd(A_STAT, r); chk("stat_full_ovf", r, 32'h0006_0008);
    chk("irq_ovf", irq, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      rd(A_DATA, r); chk($sformatf("ovf_word%0d", k), r, model(32'h1, 32 * k));
    end
    rd(A_STAT, r); chk("stat_drained", r, 32'h0005_0000);
    wr(A_STAT, 32'h0004_0000);
    tick(1);
    chk("irq_ovf_clr", irq, 1'b0);

    // Threshold interrupt at level 4
    wr(A_SEED, 32'h1);
    wr(A_CTRL, 32'h0405);
    tick(127);
    chk("thr_level4", dbg[40:32], 9'd4);
    chk("thr_irq_lag", irq, 1'b0);
    tick(1);
    chk("thr_irq_up", irq, 1'b1);
    wr(A_CTRL, 32'h0404);
    chk("thr_irq_hold", irq, 1'b1);
    rd(A_DATA, r); chk("thr_pop", r, model(32'h1, 32));
    chk("thr_level3", dbg[40:32], 9'd3);
    chk("thr_irq_down", irq, 1'b0);
    wr(A_CTRL, 32'h8);
    chk("flush_level", dbg[40:32], 9'd0);

    // Serial port reproduces a known word MSB first
    wr(A_SEED, 32'h1234_5678);
    wr(A_CTRL, 32'h1);
    tick(31);
    wr(A_CTRL, 32'h2);
    w = model(32'h1234_5678, 32);
    chk("spi_level1", dbg[40:32], 9'd1);
    for (int b = 31; b >= 0; b--) begin
      spi_edge();
      chk($sformatf("spi_bit%0d", b), spi_data, w[b]);
    end
    spi_edge();
    chk("spi_empty_load", spi_data, 1'b0);
    wr(A_CTRL, 32'h8);
    chk("spi_flush_sh", dbg[127:96], 32'h0);

    // Fill to full, then collide a bus pop with a serial load
    wr(A_SEED, 32'h1);
    wr(A_CTRL, 32'h1);
    tick(258);
    wr(A_CTRL, 32'h2);
    chk("fill_level8", dbg[40:32], 9'd8);
    spi_clk = 1'b1;
    tick(2);
    rd(A_DATA, r); chk("clash_wb_word", r, model(32'h1, 32));
    chk("clash_spi0", spi_data, 1'b0);
    chk("clash_sh0", dbg[127:96], 32'h0);
    chk("clash_level7", dbg[40:32], 9'd7);
    spi_clk = 1'b0; tick(4);
    spi_edge();
    w = model(32'h1, 64);
    chk("load_msb", spi_data, w[31]);
    chk("load_sh", dbg[127:96], w);
    chk("load_level6", dbg[40:32], 9'd6);
    wr(A_SEED, 32'h1);
    wr(A_CTRL, 32'h3);
    tick(65);
    wr(A_CTRL, 32'h2);
    rd(A_STAT, r); chk("refill_full", r, 32'h0002_0008);
    wr(A_CTRL, 32'hA);
    chk("flush_full_level", dbg[40:32], 9'd0);
    chk("flush_full_sh", dbg[127:96], 32'h0);
    rd(A_STAT, r); chk("flush_full_stat", r, 32'h0001_0000);

    // Access outside the window is ignored
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3013_3800;
    tick(1);
    chk("oow_ack1", ack, 1'b0);
    tick(1);
    chk("oow_ack2", ack, 1'b0);
    chk("oow_dat", dat_o, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    tick(1);

    // Reset during an ack cycle drops it at once
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_CTRL;
    tick(1);
    chk("pre_rst_ack", ack, 1'b1);
    chk("pre_rst_dat", dat_o, 32'h0000_0002);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_dat", dat_o, 32'h0);
    stb = 1'b0; cyc = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_debug", dbg, {32'h0, 32'h0, 32'h0001_0000, 32'hACE1_0001});

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
